// File: rtl/tape_mem.sv
// tape_mem: shared data-tape RAM; zero-fills after reset, then serves one store
// and one pipelined load per edge with store-to-load forwarding.
module tape_mem #(
    parameter int DEPTH = 65536,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic        st_en,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    output logic [15:0] ld_data,
    output logic        ld_valid,
    output logic        ready,
    output logic        err
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nx;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] fill, ld_idx, st_idx, waddr, a_idx;
    logic [15:0]   wdata, rd_q, a_fd, b_data;
    logic          run, ld_go, st_go, we, a_v, a_fwd, b_v;
    assign ld_idx = ld_addr[AW-1:0];
    assign st_idx = st_addr[AW-1:0];
    assign run    = state == RUN;
    assign ready  = run;
    assign ld_go  = run && ld_en;
    assign st_go  = run && st_en;
    if (AW < 16) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^{ld_addr[15:AW], st_addr[15:AW]};
    end
    always_comb begin
        state_nx = (state == INIT && &fill) ? RUN : state;
        we       = run ? st_en : 1'b1;
        waddr    = run ? st_idx : fill;
        wdata    = run ? st_data : 16'h0000;
    end
    // RAM array and its read register stay out of reset so they map onto block RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (ld_go) rd_q <= mem[ld_idx];
    end
    // a_* holds the accepted load; b_* the resolved word that ld_data presents next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            fill     <= '0;
            err      <= 1'b0;
            a_v      <= 1'b0;
            a_idx    <= '0;
            a_fwd    <= 1'b0;
            a_fd     <= '0;
            b_v      <= 1'b0;
            b_data   <= '0;
            ld_valid <= 1'b0;
            ld_data  <= '0;
        end else begin
            state <= state_nx;
            if (!run) fill <= fill + 1'b1;
            if (!run && (ld_en || st_en)) err <= 1'b1;
            a_v    <= ld_go;
            a_idx  <= ld_idx;
            a_fwd  <= st_go && st_idx == ld_idx;
            a_fd   <= st_data;
            b_v    <= a_v;
            b_data <= (st_go && st_idx == a_idx) ? st_data : a_fwd ? a_fd : rd_q;
            ld_valid <= b_v;
            if (b_v) ld_data <= b_data;
        end
    end
endmodule

// File: tb/tb_tape_mem.sv
// tb_tape_mem: directed checks of tape_mem (DEPTH=16) against a word-array model.
module tb_tape_mem;
    localparam int D = 16;
    logic        clk = 1'b0, rst_n = 1'b0, ld_en = 1'b0, st_en = 1'b0;
    logic [15:0] ld_addr = '0, st_addr = '0, st_data = '0;
    logic [15:0] ld_data;
    logic        ld_valid, ready, err;
    int          total = 0, passed = 0;
    bit          go = 1'b0;

    tape_mem #(.DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr),
        .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
        .ld_data(ld_data), .ld_valid(ld_valid), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Model: fill lasts D edges; a load sampled at E returns the tape word as it
    // stands after the store of E+1, presented from E+2 on.
    int          n_edges = 0, p1_idx = 0;
    logic [15:0] mm [D];
    logic [15:0] m_data = '0, p2_d = '0;
    logic        m_ready = 1'b0, m_err = 1'b0, m_v = 1'b0, p1_v = 1'b0, p2_v = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edges = 0; m_ready = 0; m_err = 0; m_v = 0; m_data = 0; p1_v = 0; p2_v = 0;
            foreach (mm[i]) mm[i] = 16'h0000;
        end else begin
            n_edges++;
            m_v = p2_v;
            if (p2_v) m_data = p2_d;
            if (n_edges <= D) begin
                if (ld_en || st_en) m_err = 1;
                p1_v = 0;
                p2_v = 0;
            end else begin
                if (st_en) mm[int'(st_addr) % D] = st_data;
                p2_v = p1_v;
                p2_d = mm[p1_idx];
                p1_v = ld_en;
                p1_idx = int'(ld_addr) % D;
            end
            m_ready = n_edges >= D;
        end
    end

    always @(negedge clk) if (go) begin
        chk("ready", {15'd0, ready}, {15'd0, m_ready});
        chk("err", {15'd0, err}, {15'd0, m_err});
        chk("ld_valid", {15'd0, ld_valid}, {15'd0, m_v});
        chk("ld_data", ld_data, m_data);
    end

    task automatic cyc(input logic l, input logic [15:0] la, input logic s,
                       input logic [15:0] sa, input logic [15:0] sd);
        ld_en = l; ld_addr = la; st_en = s; st_addr = sa; st_data = sd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic resp(input string nm, input logic v, input logic [15:0] d);
        chk({nm, "_valid"}, {15'd0, ld_valid}, {15'd0, v});
        chk({nm, "_data"}, ld_data, d);
    endtask

    task automatic fill_and_sweep(input bit poke);
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) begin
            cyc(poke && i == 4, 16'd2, 0, 0, 0);
            chk("fill_ready", {15'd0, ready}, (i == D - 1) ? 16'd1 : 16'd0);
            if (poke && i >= 4) chk("init_err", {15'd0, err}, 16'd1);
            if (poke && i == 6) chk("init_drop", {15'd0, ld_valid}, 16'd0);
        end
        for (int i = 0; i < D + 2; i++) begin
            cyc(i < D, 16'(i), 0, 0, 0);
            if (i >= 2) resp("zero", 1'b1, 16'h0000);
        end
        idle(1);
    endtask

    initial begin
        idle(3);
        go = 1'b1;
        fill_and_sweep(1'b1);
        cyc(0, 0, 1, 16'd3, 16'h00AB);
        cyc(1, 16'd3, 0, 0, 0);
        idle(1);
        chk("st_ld_early", {15'd0, ld_valid}, 16'd0);
        idle(1);
        resp("st_ld", 1'b1, 16'h00AB);
        cyc(1, 16'h0013, 0, 0, 0);
        idle(2);
        resp("alias", 1'b1, 16'h00AB);
        cyc(1, 16'd5, 1, 16'd5, 16'h1234);
        idle(2);
        resp("fwd_same", 1'b1, 16'h1234);
        cyc(1, 16'd6, 0, 0, 0);
        cyc(0, 0, 1, 16'd6, 16'h5555);
        cyc(0, 0, 1, 16'd6, 16'h7777);
        resp("fwd_next", 1'b1, 16'h5555);
        idle(1);
        resp("hold", 1'b0, 16'h5555);
        cyc(1, 16'd6, 0, 0, 0);
        idle(2);
        resp("late_store", 1'b1, 16'h7777);
        cyc(0, 0, 1, 16'd1, 16'h0011);
        cyc(0, 0, 1, 16'd2, 16'h0022);
        cyc(0, 0, 1, 16'd3, 16'h0033);
        cyc(1, 16'd1, 0, 0, 0);
        cyc(1, 16'd2, 0, 0, 0);
        cyc(1, 16'd3, 0, 0, 0);
        resp("pipe1", 1'b1, 16'h0011);
        idle(1);
        resp("pipe2", 1'b1, 16'h0022);
        idle(1);
        resp("pipe3", 1'b1, 16'h0033);
        idle(1);
        resp("pipe_end", 1'b0, 16'h0033);
        cyc(1, 16'd5, 0, 0, 0);
        cyc(1, 16'd6, 0, 0, 0);
        idle(1);
        resp("pre_rst", 1'b1, 16'h1234);
        chk("pre_rst_ready", {15'd0, ready}, 16'd1);
        chk("pre_rst_err", {15'd0, err}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {15'd0, ld_valid}, 16'd0);
        chk("rst_ready", {15'd0, ready}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        @(negedge clk);
        idle(2);
        fill_and_sweep(1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tape_mem.md
# tape_mem

Shared data-tape responder for the multicore array. It sits at the tail of the daisy-chained memory request bus driven by the per-core select stages and owns the tape RAM. It services at most one load and one store per cycle, and returns load data with a fixed two-edge latency that matches the select stage's `ld_en` → `ld_en1` → `ld_en2` pipeline. After reset it zero-fills the tape and then raises `ready`, which the top level uses to hold every core's enable low until then.

## Interface

Parameters:
- `DEPTH`, 65536 — tape words. Power of two, ≥ 4.
- `AW`, `$clog2(DEPTH)` — index bits. Addresses use the low `AW` bits of the 16-bit bus address; upper bits are ignored, so addresses wrap modulo `DEPTH`.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `ld_en` in 1 — load request, valid in the current cycle.
- `ld_addr` in 16 — load address.
- `st_en` in 1 — store request, valid in the current cycle.
- `st_addr` in 16 — store address.
- `st_data` in 16 — store data.
- `ld_data` out 16 — load response data.
- `ld_valid` out 1 — `ld_data` holds a response this cycle. Provided for verification and debug; the select stages do not need it.
- `ready` out 1 — zero-fill is complete and requests are being serviced.
- `err` out 1 — sticky flag: a request arrived while `ready`=0.

## Operation

- FSM has two states, `INIT` and `RUN`.
- Reset asserted: state = `INIT`, fill counter = 0, `ready`=0, `ld_valid`=0, `ld_data`=0, `err`=0, pipeline valids cleared. RAM contents are not reset directly.
- `INIT`, one word per edge:
  - Writes 0 to `RAM[fill]`, then increments `fill`.
  - When a write lands at `DEPTH-1`, the FSM moves to `RUN`; `ready` is registered high on that same edge.
  - The fill takes exactly `DEPTH` edges after `rst_n` rises.
  - Any `ld_en` or `st_en` seen in `INIT` is dropped and sets `err`. Such a load produces no response.
- `RUN`, store: on the edge where `st_en`=1, write `RAM[st_addr[AW-1:0]] <= st_data`.
- `RUN`, load: on the edge where `ld_en`=1, read `RAM[ld_addr[AW-1:0]]` into stage 1 (valid, index, data). On the next edge stage 1 moves to stage 2, which drives `ld_data`/`ld_valid`.
- Store-to-load ordering. A store ordered before a load must be visible to that load.
  - Same-edge store and load, same index: the store counts as older. Stage 1 captures `st_data` instead of the RAM value.
  - Store on the edge between load acceptance and output, while the load is in stage 1, same index: stage 2 captures `st_data` instead of the stage-1 data.
  - Stores after the response edge do not alter an already-presented `ld_data`.
- Back-to-back loads on consecutive edges are fully pipelined: one response per edge, in request order.
- `ld_data` holds its last value when `ld_valid`=0.
- `err` clears only on reset.
- Asynchronous reset mid-operation:
  - In-flight loads are discarded; `ld_valid` drops immediately.
  - The fill restarts from 0, and `ready` drops immediately.

## Timing

- Load latency: request sampled at edge E0; `ld_data`/`ld_valid` are registered at E2 and valid for the whole cycle after E2. The select stage consumes the data combinationally in that cycle.
- Store latency: visible to a load sampled at the same edge (via the forwarding path) and to any later load.
- Throughput: 1 load + 1 store per edge, with no backpressure. Upstream select stages guarantee at most one requester per bus per cycle.
- `ready` rises registered at edge `DEPTH` after reset release and stays high until the next reset.
- RAM: single synchronous write port and one synchronous read port. The read-during-write result is irrelevant, because the forwarding path overrides it.

## Test plan

- Reset/init, `DEPTH`=16: `ready`=0 for 16 edges after `rst_n` rises, then 1. Loads of addresses 0..15 each return 0 exactly two edges after request, with `ld_valid` pulsing 1.
- Store then load, `DEPTH`=16: store 0x00AB to address 3 at edge E; load address 3 at E+1 → `ld_data`=0x00AB, `ld_valid`=1 in the cycle after E+3. Address 0x0013 aliases to index 3 and returns 0x00AB.
- Forwarding:
  - Store 0x1234 and load of address 5 on the same edge → response 0x1234.
  - Load address 6 at E, store 0x5555 to address 6 at E+1 → response 0x5555.
  - Store to address 6 at E+2 → response keeps its old value.
- Pipelining: loads of addresses 1, 2, 3 on consecutive edges after storing 0x11, 0x22, 0x33 there → `ld_valid` high for 3 consecutive cycles with data 0x11, 0x22, 0x33 in order.
- Init violation: `ld_en`=1 during `INIT` → `err`=1 and stays 1; no `ld_valid` pulse for that request.
- Mid-operation reset: assert `rst_n`=0 with a load in flight → `ld_valid`, `ready` and `err` are 0 immediately. After release, the 16-edge fill repeats and all words read 0.
